// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch stage and its helpers.
package if_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Jump-kind encoding that selects the absolute jump target.
    localparam logic [1:0] JUMP_ABS = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } fetch_state_e;

    // Payload handed across the IF/ID boundary.
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pc4;
    } if_id_t;

endpackage

// File: rtl/if_npc_sel.sv
// Next-PC selection: redirect decision, redirect target and sequential PC.
module if_npc_sel
    import if_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic [XLEN-1:0] pc_q,
    input  logic [1:0]      jump,
    input  logic [XLEN-1:0] jump_addr,
    input  logic            pc_src,
    input  logic [XLEN-1:0] branch_addr,
    output logic            redirect_c,
    output logic [XLEN-1:0] target_c,
    output logic [XLEN-1:0] pc_plus4_c
);

    logic jump_abs;

    // Absolute jump outranks a taken branch when both arrive together.
    always_comb begin
        jump_abs   = (jump == JUMP_ABS);
        redirect_c = jump_abs | pc_src;
        target_c   = jump_abs ? jump_addr : branch_addr;
        pc_plus4_c = pc_q + XLEN'(4);
    end

endmodule

// File: rtl/if_fetch_ctrl.sv
// IF-stage fetch sequencer: owns the PC, issues one instruction-memory
// request at a time, squashes wrong-path responses and presents the fetched
// instruction with its PC and PC+4.
module if_fetch_ctrl
    import if_pkg::*;
#(
    parameter logic [31:0]  RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned  XLEN     = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            pc_src,
    input  logic [XLEN-1:0] branch_addr,
    input  logic [1:0]      jump,
    input  logic [XLEN-1:0] jump_addr,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            out_valid,
    output logic [XLEN-1:0] out_inst,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_pc4
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            squash_q, squash_d;
    logic            req_d;
    logic [XLEN-1:0] addr_d;
    logic            valid_d;
    if_id_t          out_q, out_d;

    logic            redirect_c;
    logic [XLEN-1:0] target_c;
    logic [XLEN-1:0] pc_plus4_c;

    if_npc_sel #(.XLEN(XLEN)) u_npc_sel (
        .pc_q        (pc_q),
        .jump        (jump),
        .jump_addr   (jump_addr),
        .pc_src      (pc_src),
        .branch_addr (branch_addr),
        .redirect_c  (redirect_c),
        .target_c    (target_c),
        .pc_plus4_c  (pc_plus4_c)
    );

    // Next-state, PC, squash, request and IF/ID payload decisions.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        squash_d = squash_q;
        req_d    = imem_req;
        addr_d   = imem_addr;
        valid_d  = out_valid;
        out_d    = out_q;

        case (state_q)
            IDLE: begin
                state_d = FETCH;
                req_d   = 1'b1;
                if (redirect_c) begin
                    pc_d   = target_c;
                    addr_d = target_c;
                end else begin
                    addr_d = pc_q;
                end
            end

            FETCH: begin
                // Address is frozen while the request is pending; a redirect
                // only retargets the PC and marks the response as wrong-path.
                if (redirect_c) begin
                    pc_d     = target_c;
                    squash_d = 1'b1;
                end
                if (imem_ready) begin
                    state_d = WAIT;
                    req_d   = 1'b0;
                end
            end

            WAIT: begin
                if (imem_rvalid) begin
                    if (redirect_c || squash_q) begin
                        // Wrong-path data: drop it and refetch from the PC.
                        state_d  = FETCH;
                        squash_d = 1'b0;
                        req_d    = 1'b1;
                        pc_d     = redirect_c ? target_c : pc_q;
                        addr_d   = redirect_c ? target_c : pc_q;
                    end else begin
                        state_d   = HOLD;
                        valid_d   = 1'b1;
                        out_d.inst = imem_rdata;
                        out_d.pc   = pc_q;
                        out_d.pc4  = pc_plus4_c;
                    end
                end else if (redirect_c) begin
                    pc_d     = target_c;
                    squash_d = 1'b1;
                end
            end

            HOLD: begin
                if (redirect_c) begin
                    state_d = FETCH;
                    valid_d = 1'b0;
                    req_d   = 1'b1;
                    pc_d    = target_c;
                    addr_d  = target_c;
                end else if (!stall) begin
                    state_d = FETCH;
                    valid_d = 1'b0;
                    req_d   = 1'b1;
                    pc_d    = pc_plus4_c;
                    addr_d  = pc_plus4_c;
                end
            end

            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // State, PC and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            pc_q      <= XLEN'(RESET_PC);
            squash_q  <= 1'b0;
            imem_req  <= 1'b0;
            imem_addr <= XLEN'(RESET_PC);
            out_valid <= 1'b0;
            out_q     <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            squash_q  <= squash_d;
            imem_req  <= req_d;
            imem_addr <= addr_d;
            out_valid <= valid_d;
            out_q     <= out_d;
        end
    end

    assign out_inst = out_q.inst;
    assign out_pc   = out_q.pc;
    assign out_pc4  = out_q.pc4;

endmodule
